// File: rtl/spi_slave_collector.sv
// SPI slave collector: oversamples an SPI bus, pushes received words into a FWFT FIFO and shifts a response word on MISO.
// Optional build macro SPI_SLAVE_COLLECTOR_LOOPBACK_EN echoes the last received word on MISO instead of tx_data.
module spi_slave_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int MSB_FIRST  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sclk,
    input  logic                          cs_n,
    input  logic                          mosi,
    output logic                          miso,
    input  logic [DATA_WIDTH-1:0]         tx_data,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          frame_err,
    output logic [15:0]                   word_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // Input synchronisers and edge-detect history
    logic sclk_meta_reg, sclk_sync_reg, sclk_prev_reg;
    logic cs_meta_reg, cs_sync_reg, cs_prev_reg;
    logic mosi_meta_reg, mosi_sync_reg;
    logic [1:0] fill_reg;
    logic armed_reg;

    // Serial engine state
    state_t                state_reg;
    logic [BW-1:0]         bit_cnt_reg;
    logic [DATA_WIDTH-1:0] rx_sr_reg;
    logic [DATA_WIDTH-1:0] tx_sr_reg;
    logic                  tx_first_reg;
    logic                  miso_reg;
    logic                  push_reg;
    logic [DATA_WIDTH-1:0] push_data_reg;
    logic [15:0]           word_cnt_reg;
    logic                  frame_err_reg;

    // FIFO state
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]           level_reg;
    logic                  overflow_reg;

    // Combinational helpers
    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_rise, word_done;
    logic [DATA_WIDTH-1:0] rx_shift_next, tx_shifted, load_fall, load_done;
    logic tx_bit;
    logic do_pop, do_push, drop, full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta_reg <= 1'(CPOL);
            sclk_sync_reg <= 1'(CPOL);
            sclk_prev_reg <= 1'(CPOL);
            cs_meta_reg   <= 1'b1;
            cs_sync_reg   <= 1'b1;
            cs_prev_reg   <= 1'b1;
            mosi_meta_reg <= 1'b0;
            mosi_sync_reg <= 1'b0;
            fill_reg      <= 2'd0;
            armed_reg     <= 1'b0;
        end else begin
            sclk_meta_reg <= sclk;
            sclk_sync_reg <= sclk_meta_reg;
            sclk_prev_reg <= sclk_sync_reg;
            cs_meta_reg   <= cs_n;
            cs_sync_reg   <= cs_meta_reg;
            cs_prev_reg   <= cs_sync_reg;
            mosi_meta_reg <= mosi;
            mosi_sync_reg <= mosi_meta_reg;
            if (fill_reg != 2'd2)
                fill_reg <= fill_reg + 2'd1;
            // A frame already in progress at reset release is ignored until cs_n is seen high.
            armed_reg <= armed_reg | ((fill_reg == 2'd2) & cs_sync_reg);
        end
    end

    always_comb begin
        sclk_rise  = sclk_sync_reg & ~sclk_prev_reg;
        sclk_fall  = ~sclk_sync_reg & sclk_prev_reg;
        lead_edge  = (CPOL != 0) ? sclk_fall : sclk_rise;
        trail_edge = (CPOL != 0) ? sclk_rise : sclk_fall;
        sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
        shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
        cs_fall = cs_prev_reg & ~cs_sync_reg & armed_reg;
        cs_rise = ~cs_prev_reg & cs_sync_reg;
        if (MSB_FIRST != 0) begin
            rx_shift_next = {rx_sr_reg[DATA_WIDTH-2:0], mosi_sync_reg};
            tx_bit        = tx_sr_reg[DATA_WIDTH-1];
            tx_shifted    = {tx_sr_reg[DATA_WIDTH-2:0], 1'b0};
        end else begin
            rx_shift_next = {mosi_sync_reg, rx_sr_reg[DATA_WIDTH-1:1]};
            tx_bit        = tx_sr_reg[0];
            tx_shifted    = {1'b0, tx_sr_reg[DATA_WIDTH-1:1]};
        end
        word_done = (state_reg == ACTIVE) && !cs_rise && sample_edge && (bit_cnt_reg == LAST_BIT);
    end

`ifdef SPI_SLAVE_COLLECTOR_LOOPBACK_EN
    logic [DATA_WIDTH-1:0] last_rx_reg;
    logic                  unused_tx;

    assign unused_tx = ^tx_data;
    // The word just completed is echoed straight away in the next MISO word.
    assign load_fall = last_rx_reg;
    assign load_done = rx_shift_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_rx_reg <= '0;
        else if (word_done)
            last_rx_reg <= rx_shift_next;
    end
`else
    assign load_fall = tx_data;
    assign load_done = tx_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            rx_sr_reg     <= '0;
            tx_sr_reg     <= '0;
            tx_first_reg  <= 1'b0;
            miso_reg      <= 1'b0;
            push_reg      <= 1'b0;
            push_data_reg <= '0;
            word_cnt_reg  <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            push_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            tx_first_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    bit_cnt_reg <= '0;
                    miso_reg    <= 1'b0;
                    if (cs_fall) begin
                        state_reg    <= ACTIVE;
                        tx_sr_reg    <= load_fall;
                        tx_first_reg <= (CPHA == 0);
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_reg   <= IDLE;
                        bit_cnt_reg <= '0;
                        miso_reg    <= 1'b0;
                        if (bit_cnt_reg != '0)
                            frame_err_reg <= 1'b1;
                    end else begin
                        // CPHA=0 presents the first bit before any clock edge.
                        if (tx_first_reg) begin
                            miso_reg  <= tx_bit;
                            tx_sr_reg <= tx_shifted;
                        end
                        if (sample_edge) begin
                            rx_sr_reg <= rx_shift_next;
                            if (word_done) begin
                                bit_cnt_reg   <= '0;
                                push_reg      <= 1'b1;
                                push_data_reg <= rx_shift_next;
                                word_cnt_reg  <= word_cnt_reg + 16'd1;
                                tx_sr_reg     <= load_done;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + BW'(1);
                            end
                        end else if (shift_edge) begin
                            miso_reg  <= tx_bit;
                            tx_sr_reg <= tx_shifted;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        full    = (level_reg == FULL_LEVEL);
        do_pop  = (level_reg != '0) && rx_ready;
        do_push = push_reg && (!full || do_pop);
        drop    = push_reg && full && !do_pop;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= push_data_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + (AW + 1)'(1);
                2'b01:   level_reg <= level_reg - (AW + 1)'(1);
                default: level_reg <= level_reg;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)
                overflow_reg <= 1'b1;
            else if (ovf_clr)
                overflow_reg <= 1'b0;
        end
    end

    assign miso      = miso_reg;
    assign rx_valid  = (level_reg != '0);
    assign rx_data   = rx_valid ? mem[rd_ptr_reg] : '0;
    assign rx_level  = level_reg;
    assign overflow  = overflow_reg;
    assign frame_err = frame_err_reg;
    assign word_cnt  = word_cnt_reg;

endmodule

// File: tb/tb_spi_slave_collector.sv
// Directed bench: four collector instances (SPI modes 0..3, mode 3 LSB first), FIFO depth 4.
module tb_spi_slave_collector;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 3;
    localparam int H     = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] sclk_b     = 4'b1100;
    logic [3:0] cs_b       = 4'hF;
    logic [3:0] mosi_b     = 4'h0;
    logic [3:0] rx_ready_b = 4'h0;
    logic [3:0] ovf_clr_b  = 4'h0;
    logic [3:0] miso_b, rx_valid_b, overflow_b, frame_err_b;
    logic [DW-1:0] tx_b [4];
    logic [DW-1:0] rx_data_b [4];
    logic [LW-1:0] lvl_b [4];
    logic [15:0]   wc_b [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            spi_slave_collector #(
                .DATA_WIDTH(DW),
                .FIFO_DEPTH(DEPTH),
                .CPOL(gi / 2),
                .CPHA(gi % 2),
                .MSB_FIRST((gi == 3) ? 0 : 1)
            ) u_dut (
                .clk(clk),
                .rst_n(rst_n),
                .sclk(sclk_b[gi]),
                .cs_n(cs_b[gi]),
                .mosi(mosi_b[gi]),
                .miso(miso_b[gi]),
                .tx_data(tx_b[gi]),
                .rx_data(rx_data_b[gi]),
                .rx_valid(rx_valid_b[gi]),
                .rx_ready(rx_ready_b[gi]),
                .rx_level(lvl_b[gi]),
                .overflow(overflow_b[gi]),
                .ovf_clr(ovf_clr_b[gi]),
                .frame_err(frame_err_b[gi]),
                .word_cnt(wc_b[gi])
            );
        end
    endgenerate

    int n_tests = 0;
    int n_fail  = 0;
    int ferr_cnt0 = 0;
    logic [DW-1:0] m_send [8];
    logic [DW-1:0] m_recv [8];
    logic [DW-1:0] lb_last [4];
    int wc_exp [4];

    always @(posedge clk) if (frame_err_b[0]) ferr_cnt0 <= ferr_cnt0 + 1;

    typedef struct {
        int            idx;
        logic [DW-1:0] send;
        logic [DW-1:0] tx;
        logic [DW-1:0] exp_rx;
    } vec_t;
    vec_t tbl [7];

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Master side of one cs_n frame; the final word may be cut short to nb_last bits.
    task automatic xfer(input int idx, input int nw, input int nb_last, input bit keep_cs);
        bit cpol, cpha, msb;
        int nb, bi;
        logic [DW-1:0] rw;
        cpol = (idx / 2) != 0;
        cpha = (idx % 2) != 0;
        msb  = (idx != 3);
        cs_b[idx] = 1'b0;
        wait_clk(H);
        for (int w = 0; w < nw; w++) begin
            nb = (w == nw - 1) ? nb_last : DW;
            rw = '0;
            for (int b = 0; b < nb; b++) begin
                bi = msb ? (DW - 1 - b) : b;
                if (!cpha) begin
                    mosi_b[idx] = m_send[w][bi];
                    wait_clk(H);
                    sclk_b[idx] = ~cpol;
                    rw[bi] = miso_b[idx];
                    wait_clk(H);
                    sclk_b[idx] = cpol;
                end else begin
                    sclk_b[idx] = ~cpol;
                    mosi_b[idx] = m_send[w][bi];
                    wait_clk(H);
                    sclk_b[idx] = cpol;
                    rw[bi] = miso_b[idx];
                    wait_clk(H);
                end
            end
            m_recv[w] = rw;
            $display("[TB] inst %0d word %0d sent %02h master got %02h", idx, w, m_send[w], rw);
        end
        if (!keep_cs) begin
            wait_clk(H);
            cs_b[idx] = 1'b1;
            wait_clk(8);
        end
    endtask

    task automatic wait_valid(input int idx);
        int t = 0;
        while (!rx_valid_b[idx] && t < 20) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic pop_chk(input int idx, input logic [DW-1:0] exp, input string name);
        wait_valid(idx);
        chk({name, "_valid"}, rx_valid_b[idx], 1);
        chk({name, "_data"}, rx_data_b[idx], exp);
        rx_ready_b[idx] = 1'b1;
        @(negedge clk);
        rx_ready_b[idx] = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] exp_miso(input int idx, input logic [DW-1:0] tx);
`ifdef SPI_SLAVE_COLLECTOR_LOOPBACK_EN
        return lb_last[idx];
`else
        return tx;
`endif
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            tx_b[i] = '0;
            lb_last[i] = '0;
            wc_exp[i] = 0;
        end
        tbl[0] = '{0, 8'h5A, 8'hC3, 8'h5A};
        tbl[1] = '{1, 8'h01, 8'h96, 8'h01};
        tbl[2] = '{2, 8'h01, 8'h96, 8'h01};
        tbl[3] = '{3, 8'h01, 8'h96, 8'h01};
        tbl[4] = '{1, 8'hB7, 8'h4D, 8'hB7};
        tbl[5] = '{2, 8'h6E, 8'h21, 8'h6E};
        tbl[6] = '{3, 8'hC8, 8'h35, 8'hC8};

        wait_clk(3);
        chk("rst_miso", miso_b, 0);
        chk("rst_valid", rx_valid_b, 0);
        chk("rst_ovf", overflow_b, 0);
        chk("rst_ferr", frame_err_b, 0);
        chk("rst_level", lvl_b[0], 0);
        chk("rst_data", rx_data_b[0], 0);
        chk("rst_wc", wc_b[0], 0);
        rst_n = 1'b1;
        wait_clk(6);

        for (int k = 0; k < 7; k++) begin
            int idx;
            logic [DW-1:0] em;
            idx = tbl[k].idx;
            tx_b[idx] = tbl[k].tx;
            m_send[0] = tbl[k].send;
            em = exp_miso(idx, tbl[k].tx);
            xfer(idx, 1, DW, 1'b0);
            lb_last[idx] = tbl[k].send;
            wc_exp[idx]++;
            chk("tbl_miso", m_recv[0], em);
            pop_chk(idx, tbl[k].exp_rx, "tbl_rx");
            chk("tbl_wc", wc_b[idx], wc_exp[idx]);
            chk("tbl_level", lvl_b[idx], 0);
        end

        // Two words in one mode-0 frame
        begin
            logic [DW-1:0] em0, em1;
            tx_b[0] = 8'h96;
            m_send[0] = 8'hA5;
            m_send[1] = 8'h3C;
`ifdef SPI_SLAVE_COLLECTOR_LOOPBACK_EN
            em0 = lb_last[0];
            em1 = 8'hA5;
`else
            em0 = 8'h96;
            em1 = 8'h96;
`endif
            xfer(0, 2, DW, 1'b0);
            lb_last[0] = 8'h3C;
            wc_exp[0] += 2;
            chk("m0_miso0", m_recv[0], em0);
            chk("m0_miso1", m_recv[1], em1);
            chk("m0_level", lvl_b[0], 2);
            chk("m0_wc", wc_b[0], wc_exp[0]);
            pop_chk(0, 8'hA5, "m0_pop0");
            pop_chk(0, 8'h3C, "m0_pop1");
        end

        // Overflow: five words into a four-entry FIFO
        for (int i = 0; i < 5; i++) m_send[i] = 8'h10 + 8'(i);
        xfer(0, 5, DW, 1'b0);
        lb_last[0] = 8'h14;
        wc_exp[0] += 5;
        chk("ovf_level", lvl_b[0], 4);
        chk("ovf_flag", overflow_b[0], 1);
        chk("ovf_wc", wc_b[0], wc_exp[0]);
        for (int i = 0; i < 4; i++) pop_chk(0, 8'h10 + 8'(i), "ovf_pop");
        chk("ovf_sticky", overflow_b[0], 1);
        chk("ovf_empty", rx_valid_b[0], 0);
        ovf_clr_b[0] = 1'b1;
        @(negedge clk);
        ovf_clr_b[0] = 1'b0;
        @(negedge clk);
        chk("ovf_clr", overflow_b[0], 0);

        // Frame aborted after 5 of 8 bits
        begin
            int f0;
            f0 = ferr_cnt0;
            m_send[0] = 8'hFF;
            xfer(0, 1, 5, 1'b0);
            chk("abort_pulses", ferr_cnt0 - f0, 1);
            chk("abort_level", lvl_b[0], 0);
            chk("abort_wc", wc_b[0], wc_exp[0]);
            m_send[0] = 8'h7E;
            xfer(0, 1, DW, 1'b0);
            chk("abort_next_miso", m_recv[0], exp_miso(0, tx_b[0]));
            lb_last[0] = 8'h7E;
            wc_exp[0]++;
            pop_chk(0, 8'h7E, "abort_next");
        end

        // Reset in the middle of a word with two words queued
        m_send[0] = 8'h11;
        m_send[1] = 8'h22;
        xfer(0, 2, DW, 1'b0);
        chk("rm_level_pre", lvl_b[0], 2);
        m_send[0] = 8'hAA;
        xfer(0, 1, 3, 1'b1);
        rst_n = 1'b0;
        wait_clk(2);
        chk("rm_miso", miso_b[0], 0);
        chk("rm_valid", rx_valid_b[0], 0);
        chk("rm_level", lvl_b[0], 0);
        chk("rm_data", rx_data_b[0], 0);
        chk("rm_wc", wc_b[0], 0);
        chk("rm_ovf", overflow_b[0], 0);
        chk("rm_ferr", frame_err_b[0], 0);
        cs_b[0] = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) lb_last[i] = '0;
        wait_clk(6);
        tx_b[0] = 8'h96;
        m_send[0] = 8'h55;
        xfer(0, 1, DW, 1'b0);
        chk("rm_next_miso", m_recv[0], exp_miso(0, 8'h96));
        chk("rm_next_level", lvl_b[0], 1);
        chk("rm_next_wc", wc_b[0], 1);
        pop_chk(0, 8'h55, "rm_next");
        chk("rm_next_empty", rx_valid_b[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
